bcd3_countdown: RTL and testbench
=================================

# bcd3_countdown

Registered three-digit BCD down-counter/timer: the decrementing counterpart to the combinational three-digit BCD incrementer. A BCD value 000–999 is loaded. The block decrements it by one on each qualified tick and flags expiry with a one-cycle `done` pulse. It serves as the countdown/timeout engine next to the incrementer-based up-counters and drives BCD seven-segment display paths directly.

## Interface
- `WRAP`, default 0: 0 = one-shot (stop at 000); 1 = periodic (reload the last loaded value on expiry and keep running).

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `load` input 1: capture `din` when not running.
- `din` input 12: BCD value {hundreds[11:8], tens[7:4], ones[3:0]}.
- `start` input 1: begin counting.
- `abort` input 1: stop counting and hold the current value.
- `tick` input 1: decrement enable, one count per cycle while high in RUN.
- `dout` output 12: current BCD count.
- `zero` output 1: combinational, `dout == 12'h000`.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle registered expiry pulse.
- `err` output 1: sticky flag for an invalid BCD load.

## Operation
- States are IDLE, RUN and DONE. Reset puts the block in IDLE with `dout`=000, internal reload register=000, `done`=0, `err`=0, `busy`=0.
- **Load (IDLE/DONE only):**
  - If every digit of `din` is ≤ 9: `dout` and the reload register take `din`, `err` clears, and the state becomes IDLE.
  - If any digit of `din` is > 9: `dout` and the reload register are unchanged, and `err` is set.
  - `err` stays set until the next valid load or reset.
  - `load` is ignored in RUN.
- **Start:**
  - In IDLE or DONE with `dout` ≠ 000: go to RUN.
  - In IDLE or DONE with `dout` = 000: go to DONE and pulse `done` for one cycle.
  - `start` is ignored in RUN.
  - If `load` and `start` occur in the same cycle, the load wins and `start` is dropped.
- **RUN, tick=1, `dout` > 001:** BCD decrement.
  - Ones digit 0 → 9 with a borrow; otherwise ones − 1.
  - Tens digit decrements only on a borrow from ones; 0 → 9 with a borrow on to hundreds.
  - Hundreds digit decrements only on a borrow from tens.
  - Results are always valid BCD.
- **RUN, tick=1, `dout` = 001 (expiry):**
  - `done` pulses.
  - With WRAP=0: `dout` becomes 000 and the state becomes DONE.
  - With WRAP=1: `dout` takes the reload register value (000 is skipped) and the state stays RUN, giving a period of exactly N ticks for a loaded N.
  - With WRAP=1 and reload = 000 (start is then impossible), the state stays in IDLE.
- **RUN, tick=0:** hold.
- **Abort:** in RUN, go to IDLE with `dout` held. A later `start` resumes from the held value. Abort has no effect elsewhere.
- Priority: reset > abort > tick. With abort and the expiry tick in the same cycle, abort wins: no `done`, `dout` stays 001.
- In DONE: `dout` holds, and only `load`/`start` act.

## Timing
- All outputs except `zero` are registered.
- Decrement latency is one cycle: `tick` sampled on edge k updates `dout` after edge k.
- `done` is high for exactly one cycle, starting after the same edge that writes 000 (or the reload value).
  - Its rise coincides with `busy` falling (WRAP=0) or staying high (WRAP=1).
- `start`→`busy` latency is one cycle. The first decrement can occur on the edge after `busy` rises.
- A `tick` in the same cycle as `start` is not counted.
- `err` is updated on the edge that samples `load`.
- Asynchronous reset mid-RUN forces all registers to their reset values immediately. `done` never pulses from reset.
- `tick` held continuously high counts one per clock. There is no internal tick divider.

## Test plan
- Reset mid-count: load 250, start, 10 ticks (`dout`=240), assert `reset` → `dout`=000, `busy`=0, `done`=0, `err`=0 with no clock edge.
- One-shot run with borrows (WRAP=0):
  - Load 123 and start.
  - Check the borrow steps 120→119 and 100→099, then 010→009.
  - After 123 ticks: `dout`=000, one `done` pulse, `busy`=0, `zero`=1.
- Tick gating: load 005 and start, then apply the tick pattern 1,0,0,1,1,0,1,1 → `dout` steps 4,4,4,3,2,2,1,0. `done` pulses exactly once, on the final step.
- Invalid load: load 1A3 → `err`=1 and `dout` keeps its prior value 042. Then load 099 → `err`=0, `dout`=099.
- Periodic (WRAP=1): load 003, start, 9 continuous ticks → `dout` sequence 2,1,3,2,1,3,2,1,3 with `done` on ticks 3, 6 and 9. `busy` stays 1.
- Edge cases:
  - `load` of 777 during RUN is ignored.
  - Abort at `dout`=001 together with a tick → `dout`=001, no `done`, IDLE.
  - Load 000 then start → a single `done` pulse and state DONE.
  - Simultaneous load 050 and start → `dout`=050, `busy`=0.

Source files
------------

// File: rtl/bcd3_countdown_if.sv
// ---------------------------------------------------------------------------
// bcd3_countdown_if
//   Control/status bundle for the three-digit BCD countdown timer.
//   master : drives load/din/start/abort/tick, observes count and flags
//   slave  : the timer itself
//   load   - capture din (ignored while running)
//   din    - BCD value {hundreds, tens, ones}
//   start  - begin counting
//   abort  - stop counting, keep current value
//   tick   - decrement enable
//   dout   - current BCD count
//   zero   - dout == 000 (combinational)
//   busy   - counting
//   done   - one-cycle expiry pulse
//   err    - sticky invalid-BCD-load flag
// ---------------------------------------------------------------------------
interface bcd3_countdown_if;
  logic        load;
  logic [11:0] din;
  logic        start;
  logic        abort;
  logic        tick;
  logic [11:0] dout;
  logic        zero;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output load, din, start, abort, tick,
    input  dout, zero, busy, done, err
  );

  modport slave (
    input  load, din, start, abort, tick,
    output dout, zero, busy, done, err
  );
endinterface

// File: rtl/bcd3_countdown.sv
// ---------------------------------------------------------------------------
// bcd3_countdown
//   Registered three-digit BCD down-counter / timer with IDLE/RUN/DONE FSM.
//   Loads a BCD value 000-999, decrements once per tick while running and
//   raises a one-cycle done pulse on expiry. WRAP=1 reloads the last loaded
//   value on expiry and keeps running (period of N ticks for a loaded N).
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high
//     bus   - control/status bundle (slave side), see bcd3_countdown_if
// ---------------------------------------------------------------------------

// One BCD digit of the borrow chain.
module bcd3_dig_dec (
  input  logic [3:0] d_i,
  input  logic       bin_i,
  output logic [3:0] q_o,
  output logic       bout_o
);
  always_comb begin
    q_o    = d_i;
    bout_o = 1'b0;
    if (bin_i) begin
      if (d_i == 4'd0) begin
        q_o    = 4'd9;
        bout_o = 1'b1;
      end else begin
        q_o = d_i - 4'd1;
      end
    end
  end
endmodule

module bcd3_countdown #(
  parameter bit WRAP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  bcd3_countdown_if.slave  bus
);
  localparam int NUM_DIGITS = 3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [11:0] dout_q, dout_d;
  logic [11:0] reload_q, reload_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Decrement datapath: ones digit always borrows in, each higher digit
  // only moves on a borrow from below.
  logic [NUM_DIGITS-1:0][3:0] cur, dec;
  logic [NUM_DIGITS-1:0]      borrow_in, borrow_out;
  logic                       unused_top_borrow;

  assign cur               = dout_q;
  assign borrow_in         = {borrow_out[NUM_DIGITS-2:0], 1'b1};
  // A borrow out of hundreds would mean decrementing 000, which never
  // happens in RUN (expiry is caught at 001).
  assign unused_top_borrow = borrow_out[NUM_DIGITS-1];

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd3_dig_dec u_dig (
        .d_i    (cur[g]),
        .bin_i  (borrow_in[g]),
        .q_o    (dec[g]),
        .bout_o (borrow_out[g])
      );
    end
  endgenerate

  logic din_ok;
  assign din_ok = (bus.din[11:8] <= 4'd9) && (bus.din[7:4] <= 4'd9) &&
                  (bus.din[3:0] <= 4'd9);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dout_q   <= 12'h000;
      reload_q <= 12'h000;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE, DONE: begin
        // load has priority; a coincident start is dropped
        if (bus.load) begin
          if (din_ok) begin
            dout_d   = bus.din;
            reload_d = bus.din;
            err_d    = 1'b0;
            state_d  = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.start) begin
          if (dout_q != 12'h000) begin
            state_d = RUN;
          end else if (!WRAP) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
          // periodic mode with nothing loaded: nothing to time, stay put
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.tick) begin
          if (dout_q == 12'h001) begin
            done_d = 1'b1;
            if (WRAP) begin
              dout_d = reload_q;  // skip 000 so period is exactly N ticks
            end else begin
              dout_d  = 12'h000;
              state_d = DONE;
            end
          end else begin
            dout_d = dec;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout = dout_q;
  assign bus.zero = (dout_q == 12'h000);
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd3_countdown.sv
// ---------------------------------------------------------------------------
// tb_bcd3_countdown
//   Directed bench for bcd3_countdown. Two instances: one-shot (u_a) and
//   periodic (u_b). Expected {busy,done,err,zero,dout} words are pushed to a
//   scoreboard when stimulus is applied and popped when outputs are sampled.
// ---------------------------------------------------------------------------
module tb_bcd3_countdown;
  logic clk;
  logic reset;

  bcd3_countdown_if ifa ();
  bcd3_countdown_if ifb ();

  bcd3_countdown #(.WRAP(1'b0)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  bcd3_countdown #(.WRAP(1'b1)) u_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] obs_a = {ifa.busy, ifa.done, ifa.err, ifa.zero, ifa.dout};
  wire [15:0] obs_b = {ifb.busy, ifb.done, ifb.err, ifb.zero, ifb.dout};

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [11:0] int2bcd(int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [15:0] ex(logic b, logic dn, logic e, logic [11:0] d);
    return {b, dn, e, (d == 12'h000), d};
  endfunction

  task automatic push(string tag, logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(logic [15:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: got %h want <entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_bad++;
        $error("FAIL %s: got %h want %h (busy,done,err,zero,dout)", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int          pat  [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
  int          gexp [8] = '{4, 4, 4, 3, 2, 2, 1, 0};
  logic [11:0] pexp [9] = '{12'h002, 12'h001, 12'h003, 12'h002, 12'h001,
                            12'h003, 12'h002, 12'h001, 12'h003};

  initial begin
    reset = 1'b1;
    ifa.load = 0; ifa.din = '0; ifa.start = 0; ifa.abort = 0; ifa.tick = 0;
    ifb.load = 0; ifb.din = '0; ifb.start = 0; ifb.abort = 0; ifb.tick = 0;
    cyc(); cyc();
    reset = 1'b0;
    push("reset_a", ex(0, 0, 0, 12'h000)); chk(obs_a);
    push("reset_b", ex(0, 0, 0, 12'h000)); chk(obs_b);

    // reset mid-count
    ifa.din = 12'h250; ifa.load = 1; cyc(); ifa.load = 0;
    push("load250", ex(0, 0, 0, 12'h250)); chk(obs_a);
    ifa.start = 1; cyc(); ifa.start = 0;
    push("start250", ex(1, 0, 0, 12'h250)); chk(obs_a);
    ifa.tick = 1;
    repeat (10) cyc();
    ifa.tick = 0;
    push("ten_ticks", ex(1, 0, 0, 12'h240)); chk(obs_a);
    #2 reset = 1'b1;
    #1;
    push("async_reset", ex(0, 0, 0, 12'h000)); chk(obs_a);
    cyc();
    reset = 1'b0;

    // one-shot with borrows
    ifa.din = 12'h123; ifa.load = 1; cyc(); ifa.load = 0;
    ifa.start = 1; ifa.tick = 1; cyc(); ifa.start = 0;
    push("start_tick_ignored", ex(1, 0, 0, 12'h123)); chk(obs_a);
    for (int i = 1; i <= 123; i++) begin
      cyc();
      push($sformatf("oneshot_%0d", i), ex(i < 123, i == 123, 0, int2bcd(123 - i)));
      chk(obs_a);
    end
    ifa.tick = 0;
    cyc();
    push("done_one_cycle", ex(0, 0, 0, 12'h000)); chk(obs_a);

    // tick gating
    ifa.din = 12'h005; ifa.load = 1; cyc(); ifa.load = 0;
    ifa.start = 1; cyc(); ifa.start = 0;
    for (int i = 0; i < 8; i++) begin
      ifa.tick = pat[i][0];
      cyc();
      push($sformatf("gate_%0d", i), ex(i < 7, i == 7, 0, int2bcd(gexp[i])));
      chk(obs_a);
    end
    ifa.tick = 0;
    cyc();
    push("gate_after", ex(0, 0, 0, 12'h000)); chk(obs_a);

    // invalid load
    ifa.din = 12'h042; ifa.load = 1; cyc();
    push("load042", ex(0, 0, 0, 12'h042)); chk(obs_a);
    ifa.din = 12'h1A3; cyc();
    push("bad_load", ex(0, 0, 1, 12'h042)); chk(obs_a);
    cyc();
    push("err_sticky", ex(0, 0, 1, 12'h042)); chk(obs_a);
    ifa.din = 12'h099; cyc(); ifa.load = 0;
    push("good_load", ex(0, 0, 0, 12'h099)); chk(obs_a);

    // load ignored in RUN
    ifa.start = 1; cyc(); ifa.start = 0;
    ifa.din = 12'h777; ifa.load = 1; cyc(); ifa.load = 0;
    push("load_in_run", ex(1, 0, 0, 12'h099)); chk(obs_a);
    ifa.abort = 1; cyc(); ifa.abort = 0;
    push("abort_idle", ex(0, 0, 0, 12'h099)); chk(obs_a);

    // abort together with the expiry tick
    ifa.din = 12'h002; ifa.load = 1; cyc(); ifa.load = 0;
    ifa.start = 1; cyc(); ifa.start = 0;
    ifa.tick = 1; cyc(); ifa.tick = 0;
    push("at_001", ex(1, 0, 0, 12'h001)); chk(obs_a);
    ifa.abort = 1; ifa.tick = 1; cyc(); ifa.abort = 0; ifa.tick = 0;
    push("abort_wins", ex(0, 0, 0, 12'h001)); chk(obs_a);
    cyc();
    push("abort_no_done", ex(0, 0, 0, 12'h001)); chk(obs_a);
    ifa.start = 1; cyc(); ifa.start = 0;
    push("resume", ex(1, 0, 0, 12'h001)); chk(obs_a);
    ifa.tick = 1; cyc(); ifa.tick = 0;
    push("resume_expire", ex(0, 1, 0, 12'h000)); chk(obs_a);

    // load 000 then start
    ifa.din = 12'h000; ifa.load = 1; cyc(); ifa.load = 0;
    push("load000", ex(0, 0, 0, 12'h000)); chk(obs_a);
    ifa.start = 1; cyc(); ifa.start = 0;
    push("start_zero", ex(0, 1, 0, 12'h000)); chk(obs_a);
    cyc();
    push("start_zero_after", ex(0, 0, 0, 12'h000)); chk(obs_a);

    // simultaneous load and start
    ifa.din = 12'h050; ifa.load = 1; ifa.start = 1; cyc();
    ifa.load = 0; ifa.start = 0;
    push("load_start", ex(0, 0, 0, 12'h050)); chk(obs_a);
    cyc();
    push("load_start_hold", ex(0, 0, 0, 12'h050)); chk(obs_a);

    // periodic instance
    ifb.din = 12'h003; ifb.load = 1; cyc(); ifb.load = 0;
    ifb.start = 1; cyc(); ifb.start = 0;
    push("wrap_start", ex(1, 0, 0, 12'h003)); chk(obs_b);
    ifb.tick = 1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      push($sformatf("wrap_%0d", i + 1), ex(1, (i % 3) == 2, 0, pexp[i]));
      chk(obs_b);
    end
    ifb.tick = 0;
    cyc();
    push("wrap_hold", ex(1, 0, 0, 12'h003)); chk(obs_b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
